mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Sole owner of the main memory read/write port; shares it between NREQ requesters (CPU load/store, front-panel loader, ...).
// - After reset, sequences an init sweep writing INIT_VAL to all 2^AW words, then arbitrates.
// - Optional per-requester lock gives back-to-back access for read-modify-write.
// - Sits between the requester mem_rwport slaves and main memory's mem_rwport slave.
// PARAMETERS
// - NREQ      3        number of requesters, >= 2
// - AW        8        address width
// - DW        16       data width
// - INIT_VAL  16'h0000 value written by the init sweep
// PORTS
// - clk_i       in   1     clock
// - rst_ni      in   1     reset; synchronous, active-low
// - req_intf    slv   -    mem_rwport.slave [0:NREQ-1]; fields val, wen, addr[AW], wdata[DW] in; rdata[DW], rdy out
// - req_lock_i  in   NREQ  per-requester lock request
// - mem_intf    mst   -    mem_rwport.master to main memory; fields val, wen, addr, wdata out; rdata, rdy in
// - gnt_o       out  NREQ  one-hot grant of the current cycle (0 when nobody is granted)
// - init_done_o out  1     1 once the sweep has completed
// BEHAVIOUR
// - Reset: rst_ni low at a posedge sets state=ARB_INIT, ptr=0, rr_ptr=0 and lock_vld=0.
//   - Outputs from the next cycle: gnt_o=0, all req rdy=0, init_done_o=0.
//   - Reset mid-operation has the same effect: grants and the lock are dropped and the sweep restarts at address 0.
// - ARB_INIT:
//   - Drives mem val=1, wen=1, addr=ptr, wdata=INIT_VAL.
//   - ptr increments only on a cycle with mem rdy=1.
//   - When the handshake at ptr=2^AW-1 completes: go to ARB_RUN and set init_done_o=1 (2^AW cycles with rdy held at 1).
//   - Requester requests are ignored (rdy=0) throughout.
// - ARB_RUN, combinational grant:
//   - If lock_vld: the lock owner wins when its val=1; otherwise no grant is given.
//   - Otherwise the winner is picked among the requesters with val=1 (see CONFIGURATION).
//   - mem val = winner exists; mem wen/addr/wdata are muxed from the winner.
//   - rdy[i] = gnt_o[i] & mem rdy; handshake = val & rdy.
// - Latency:
//   - The grant adds 0 cycles.
//   - Read data is mem rdata, broadcast to every req rdata, and is valid the cycle after the read handshake.
// - Requesters must not derive val from rdy; this rule prevents a combinational loop.
// - Lock:
//   - Handshake by the winner with req_lock_i=1 sets lock_vld and records the owner.
//   - Owner handshake with lock=0 clears lock_vld.
//   - Owner with lock=0 and val=0 also clears lock_vld.
//   - A lock request from a non-owner while lock_vld=1 has no effect.
// - mem rdy=0: no handshake occurs; rr_ptr, lock and ptr hold; muxed fields stay stable while the inputs are stable.
// - rr_ptr wraps from NREQ-1 to 0.
// - gnt_o is 0 when no requester has val=1 or during ARB_INIT.
// CONFIGURATION
// - Macro MEM_ARB_RR_EN defined: round-robin arbitration.
//   - Search starts at rr_ptr.
//   - On an unlocked handshake, rr_ptr <= (winner+1) mod NREQ.
// - Macro not defined: fixed priority, lowest index wins; rr_ptr is unused and held at 0.
// STRUCTURE
// - Shared package toy_mem_pkg holds:
//   - addr_t = logic[AW-1:0], word_t = logic[DW-1:0];
//   - enum arb_state_e {ARB_INIT, ARB_RUN};
//   - localparam ARB_SWEEP_LAST = 2^AW-1.
// - Sub-module rr_pick: combinational rotating priority picker.
//   - Inputs: req vector, start index. Output: one-hot grant.
//   - Fixed priority uses start=0.
// TESTING
// - Release reset with mem rdy=1 -> writes to addr 0x00..0xFF with data 0x0000; req rdy=0 throughout; init_done_o=1 after 256 cycles.
// - req0 writes 0xBEEF to 0x12, then reads 0x12 -> rdy=1 in the same cycle as val; rdata=0xBEEF one cycle after the read handshake.
// - req0..2 val held high:
//   - MEM_ARB_RR_EN defined -> gnt_o 001,010,100,001,...
//   - Macro not defined -> gnt_o 001 every cycle.
// - req1 locks and does an RMW on 0x40 while req0 requests -> req1 gets two consecutive handshakes, req0 stalls, then req0 is granted.
// - rst_ni low mid-traffic with a lock held -> next cycle gnt_o=0 and lock cleared; the sweep restarts at 0x00.
// - Stub mem rdy=0 for 3 cycles with requests pending -> no req rdy; rr_ptr and ptr are unchanged; the grant resumes on rdy=1.

Source files
------------

// File: rtl/toy_mem_pkg.sv
// Shared types for the toy memory subsystem: address/data words, arbiter states
// and the last address of the power-up init sweep.
package toy_mem_pkg;

  localparam int unsigned MEM_AW = 8;
  localparam int unsigned MEM_DW = 16;

  typedef logic [MEM_AW-1:0] addr_t;
  typedef logic [MEM_DW-1:0] word_t;

  typedef enum logic {
    ARB_INIT,
    ARB_RUN
  } arb_state_e;

  localparam int unsigned ARB_SWEEP_LAST = (1 << MEM_AW) - 1;

endpackage

// File: rtl/mem_rwport.sv
// Single-cycle memory read/write port: val/rdy handshake, read data one cycle later.
interface mem_rwport #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic          val;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rdy;

  modport master (output val, wen, addr, wdata, input rdata, rdy);
  modport slave  (input val, wen, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Rotating-priority picker: one-hot grant to the first set request at or after start.
module rr_pick #(
  parameter int unsigned N = 3,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(start) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory port owner: init sweep after reset, then shares the port between requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mem_arbiter
  import toy_mem_pkg::*;
#(
  parameter int unsigned   NREQ     = 3,
  parameter int unsigned   AW       = MEM_AW,
  parameter int unsigned   DW       = MEM_DW,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  mem_rwport.slave        req_intf [0:NREQ-1],
  input  logic [NREQ-1:0] req_lock_i,
  mem_rwport.master       mem_intf,
  output logic [NREQ-1:0] gnt_o,
  output logic            init_done_o
);

  localparam int unsigned IW         = $clog2(NREQ);
  localparam int unsigned SWEEP_LAST = (1 << AW) - 1;

  arb_state_e      state;
  logic [AW-1:0]   ptr;
  logic            lock_vld;
  logic [IW-1:0]   lock_own;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   pick_start;
  logic [NREQ-1:0] req_val;
  logic [NREQ-1:0] req_wen;
  logic [NREQ-1:0] pick_gnt;
  logic [NREQ-1:0] gnt_c;
  logic [AW-1:0]   req_addr  [NREQ];
  logic [DW-1:0]   req_wdata [NREQ];
  logic            run;
  logic            hs;

  // Flatten the requester ports; rdy is the grant qualified by the memory's rdy.
  for (genvar g = 0; g < NREQ; g++) begin : g_req
    assign req_val[g]         = req_intf[g].val;
    assign req_wen[g]         = req_intf[g].wen;
    assign req_addr[g]        = req_intf[g].addr;
    assign req_wdata[g]       = req_intf[g].wdata;
    assign req_intf[g].rdy    = gnt_o[g] & mem_intf.rdy;
    assign req_intf[g].rdata  = mem_intf.rdata;
  end

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] rr_ptr;
  assign pick_start = rr_ptr;
`else
  assign pick_start = '0;
`endif

  rr_pick #(.N(NREQ)) u_pick (
    .req   (req_val),
    .start (pick_start),
    .gnt   (pick_gnt)
  );

  assign run = (state == ARB_RUN);

  // A held lock bypasses the picker: only the owner may be granted.
  always_comb begin
    gnt_c   = '0;
    win_idx = '0;
    if (run) begin
      if (lock_vld) gnt_c[lock_own] = req_val[lock_own];
      else          gnt_c = pick_gnt;
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) win_idx = IW'(i);
    end
  end

  assign gnt_o = gnt_c;
  assign hs    = (|gnt_c) & mem_intf.rdy;

  assign mem_intf.val   = run ? (|gnt_c)            : 1'b1;
  assign mem_intf.wen   = run ? req_wen[win_idx]    : 1'b1;
  assign mem_intf.addr  = run ? req_addr[win_idx]   : ptr;
  assign mem_intf.wdata = run ? req_wdata[win_idx]  : INIT_VAL;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= ARB_INIT;
      ptr         <= '0;
      lock_vld    <= 1'b0;
      lock_own    <= '0;
      init_done_o <= 1'b0;
    end else if (!run) begin
      if (mem_intf.rdy) begin
        ptr <= ptr + AW'(1);
        if (ptr == AW'(SWEEP_LAST)) begin
          state       <= ARB_RUN;
          init_done_o <= 1'b1;
        end
      end
    end else if (!lock_vld) begin
      if (hs && req_lock_i[win_idx]) begin
        lock_vld <= 1'b1;
        lock_own <= win_idx;
      end
    end else if (!req_lock_i[lock_own] && (!req_val[lock_own] || hs)) begin
      // Owner released the lock, either on its last handshake or by going idle.
      lock_vld <= 1'b0;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (hs && !lock_vld) begin
      rr_ptr <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a reference model of the arbitration rules and memory contents.
module tb_mem_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] val, wen, lock, gnt, rdy;
  logic [AW-1:0]   addr  [NREQ];
  logic [DW-1:0]   wdata [NREQ];
  logic [DW-1:0]   rdata [NREQ];
  logic            mem_rdy;
  logic [DW-1:0]   mem_rdata;
  logic            init_done;
  logic [DW-1:0]   stub [256];

  mem_rwport #(.AW(AW), .DW(DW)) req_if [0:NREQ-1] ();
  mem_rwport #(.AW(AW), .DW(DW)) mem_if ();

  for (genvar g = 0; g < NREQ; g++) begin : g_if
    assign req_if[g].val   = val[g];
    assign req_if[g].wen   = wen[g];
    assign req_if[g].addr  = addr[g];
    assign req_if[g].wdata = wdata[g];
    assign rdy[g]          = req_if[g].rdy;
    assign rdata[g]        = req_if[g].rdata;
  end
  assign mem_if.rdy   = mem_rdy;
  assign mem_if.rdata = mem_rdata;

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .INIT_VAL(16'h0000)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_intf    (req_if),
    .req_lock_i  (lock),
    .mem_intf    (mem_if),
    .gnt_o       (gnt),
    .init_done_o (init_done)
  );

  always #5 clk = ~clk;

  // Stub main memory: writes land on the handshake edge, read data is registered.
  always @(posedge clk) begin
    if (mem_if.val && mem_rdy) begin
      if (mem_if.wen) stub[mem_if.addr] <= mem_if.wdata;
      else            mem_rdata <= stub[mem_if.addr];
    end
  end

  // Reference model state
  bit              m_run, m_lock, rd_pend;
  int              m_ptr, m_rr, m_own;
  logic [DW-1:0]   ref_mem [256];
  logic [DW-1:0]   rd_exp;
  logic [NREQ-1:0] last_gnt, last_rdy;
  int              n_cmp = 0;
  int              n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_ptr = 0; m_rr = 0; m_lock = 0; m_own = 0; rd_pend = 0;
    for (int a = 0; a < 256; a++) ref_mem[a] = 16'h0000;
  endtask

  // Expected grant: lock owner only, else first requester in priority order.
  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] g;
    int s;
    g = '0;
    s = 0;
    if (!m_run) return g;
    if (m_lock) begin
      g[m_own] = val[m_own];
      return g;
    end
`ifdef MEM_ARB_RR_EN
    s = m_rr;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (val[(s + k) % NREQ]) begin
        g[(s + k) % NREQ] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic cyc();
    logic [NREQ-1:0] eg;
    int w;
    bit hs, was_lock;
    w = 0;
    @(negedge clk);
    eg = model_gnt();
    for (int i = 0; i < NREQ; i++) if (eg[i]) w = i;
    last_gnt = gnt;
    last_rdy = rdy;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("req_rdy", 32'(rdy), 32'(eg & {NREQ{mem_rdy}}));
    chk("init_done", 32'(init_done), 32'(m_run));
    if (rd_pend) for (int i = 0; i < NREQ; i++) chk("rdata", 32'(rdata[i]), 32'(rd_exp));
    if (!m_run) begin
      chk("sweep_val", 32'(mem_if.val), 32'd1);
      chk("sweep_wen", 32'(mem_if.wen), 32'd1);
      chk("sweep_addr", 32'(mem_if.addr), 32'(m_ptr));
      chk("sweep_wdata", 32'(mem_if.wdata), 32'h0);
    end else begin
      chk("mem_val", 32'(mem_if.val), 32'(|eg));
      if (eg != '0) begin
        chk("mem_wen", 32'(mem_if.wen), 32'(wen[w]));
        chk("mem_addr", 32'(mem_if.addr), 32'(addr[w]));
        chk("mem_wdata", 32'(mem_if.wdata), 32'(wdata[w]));
      end
    end
    @(posedge clk);
    rd_pend = 0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_run) begin
      if (mem_rdy) begin
        if (m_ptr == 255) m_run = 1;
        m_ptr = (m_ptr + 1) % 256;
      end
    end else begin
      hs = (eg != '0) && mem_rdy;
      was_lock = m_lock;
      if (hs) begin
        if (wen[w]) ref_mem[addr[w]] = wdata[w];
        else begin
          rd_pend = 1;
          rd_exp  = ref_mem[addr[w]];
        end
      end
      if (!was_lock) begin
        if (hs && lock[w]) begin
          m_lock = 1;
          m_own  = w;
        end
      end else if (!lock[m_own] && (!val[m_own] || hs)) begin
        m_lock = 0;
      end
`ifdef MEM_ARB_RR_EN
      if (hs && !was_lock) m_rr = (w + 1) % NREQ;
`endif
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lk);
    val[i] = v; wen[i] = we; addr[i] = a; wdata[i] = d; lock[i] = lk;
  endtask

  task automatic rand_reqs(input bit with_lock);
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'($urandom), 1'($urandom), AW'(8'h10 + $urandom_range(0, 7)), DW'($urandom),
              with_lock && ($urandom_range(0, 3) == 0));
    end
  endtask

  logic [NREQ-1:0] pat [6];

  initial begin
    for (int a = 0; a < 256; a++) stub[a] = 16'hA5A5;
    val = '0; wen = '0; lock = '0; mem_rdy = 1'b1; rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin addr[i] = '0; wdata[i] = '0; end
    @(posedge clk); #1;
    model_reset();
    cyc();
    chk("reset_gnt", 32'(last_gnt), 32'h0);

    // First sweep with requesters hammering: none may be served.
    rst_n = 1'b1;
    for (int c = 0; c < 256; c++) begin
      rand_reqs(1'b1);
      cyc();
      chk("init_rdy", 32'(last_rdy), 32'h0);
    end
    chk("done_after_256", 32'(init_done), 32'd1);

    // req0 writes 0xBEEF to 0x12 then reads it back.
    val = '0; lock = '0;
    set_req(0, 1, 1, 8'h12, 16'hBEEF, 0);
    cyc();
    chk("wr_rdy", 32'(last_rdy), 32'h1);
    set_req(0, 1, 0, 8'h12, 16'h0000, 0);
    cyc();
    chk("rd_rdy", 32'(last_rdy), 32'h1);
    chk("rd_data", 32'(rdata[0]), 32'hBEEF);
    val = '0;
    cyc();

    // Align rotation with a req2 handshake, then hold all three requests.
    set_req(2, 1, 0, 8'h13, 16'h0, 0);
    cyc();
    val = 3'b111;
`ifdef MEM_ARB_RR_EN
    pat[0] = 3'b001; pat[1] = 3'b010; pat[2] = 3'b100;
    pat[3] = 3'b001; pat[4] = 3'b010; pat[5] = 3'b100;
`else
    for (int k = 0; k < 6; k++) pat[k] = 3'b001;
`endif
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("all_val_gnt", 32'(last_gnt), 32'(pat[k]));
    end

    // req1 locked read-modify-write on 0x40 while req0 waits.
    val = '0;
    set_req(1, 1, 0, 8'h40, 16'h0, 1);
    cyc();
    chk("lock_rd", 32'(last_gnt), 32'b010);
    set_req(0, 1, 1, 8'h41, 16'h1234, 1);
    set_req(1, 1, 1, 8'h40, 16'h0001, 0);
    cyc();
    chk("lock_wr", 32'(last_gnt), 32'b010);
    set_req(0, 1, 1, 8'h41, 16'h1234, 0);
    set_req(1, 0, 0, 8'h40, 16'h0, 0);
    cyc();
    chk("after_lock", 32'(last_gnt), 32'b001);

    // Reset while req1 holds a lock.
    val = '0; lock = '0;
    set_req(1, 1, 0, 8'h40, 16'h0, 1);
    cyc();
    set_req(0, 1, 0, 8'h41, 16'h0, 1);
    rst_n = 1'b0;
    cyc();
    chk("pre_rst_locked", 32'(last_gnt), 32'b010);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_gnt", 32'(last_gnt), 32'h0);
    chk("post_rst_done", 32'(init_done), 32'd0);

    // Rest of the second sweep, with a 3-cycle memory stall part way through.
    for (int c = 0; c < 258; c++) begin
      rand_reqs(1'b1);
      mem_rdy = !(c >= 10 && c < 13);
      cyc();
    end
    mem_rdy = 1'b1;
    chk("done_after_resweep", 32'(init_done), 32'd1);
    val = '0; lock = '0;
    set_req(0, 1, 0, 8'h40, 16'h0, 0);
    cyc();
    chk("lock_cleared", 32'(last_gnt), 32'b001);

    // Memory stall with all requests pending, then resume.
    val = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 1, AW'(8'h20 + i), DW'(16'h100 + i), 0);
    mem_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_rdy", 32'(last_rdy), 32'h0);
    end
    mem_rdy = 1'b1;
    cyc();
    chk("resume_rdy", 32'(|last_rdy), 32'd1);

    // Random traffic, small address window so reads hit earlier writes.
    for (int c = 0; c < 400; c++) begin
      rand_reqs(1'b1);
      mem_rdy = ($urandom_range(0, 3) != 0);
      cyc();
    end
    val = '0; lock = '0; mem_rdy = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
